// File: rtl/rsa_pkg.sv
// Shared RSA key constants and the encoder FSM state encoding.
// The rsa_decoder and mod_exp benches use the same definitions.
package rsa_pkg;
  localparam int K      = 12;
  localparam int N      = 3551;
  localparam int E      = 5;
  localparam int E_W    = 3;
  localparam int R1_MOD = 545;
  localparam int R2_MOD = 2292;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_TOMONT, S_SQR, S_MUL, S_FROMMONT, S_DONE
  } rsa_state_t;
endpackage

// File: rtl/mont_mul.sv
// Radix-2 bit-serial Montgomery multiplier: p = a*b*2^-K mod N.
// Timing: 1 load cycle, K add/shift cycles, 1 correction cycle; done is sampled K+2 edges after start.
module mont_mul #(
  parameter int K = 12,
  parameter int N = 3551
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [K-1:0] a,
  input  logic [K-1:0] b,
  output logic [K-1:0] p,
  output logic         done
);
  localparam int CW = (K > 1) ? $clog2(K) : 1;
  localparam logic [K+1:0] NW = N[K+1:0];

  logic [K-1:0]  r_a, r_b, r_p;
  logic [K+1:0]  r_acc;
  logic [CW-1:0] r_cnt;
  logic          r_run, r_corr, r_done;
  logic [K+1:0]  w_sum, w_red, w_next, w_sub;

  // acc stays below 2N, so acc + b + N < 4N fits in K+2 bits
  assign w_sum  = r_acc + (r_a[0] ? {2'b00, r_b} : '0);
  assign w_red  = w_sum + (w_sum[0] ? NW : '0);
  assign w_next = w_red >> 1;
  assign w_sub  = r_acc - NW;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_a <= '0; r_b <= '0; r_p <= '0; r_acc <= '0; r_cnt <= '0;
      r_run <= 1'b0; r_corr <= 1'b0; r_done <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (start) begin
        r_a <= a; r_b <= b; r_acc <= '0; r_cnt <= '0;
        r_run <= 1'b1; r_corr <= 1'b0;
      end else if (r_run) begin
        r_acc <= w_next;
        r_a   <= r_a >> 1;
        r_cnt <= r_cnt + 1'b1;
        if (r_cnt == CW'(K-1)) begin
          r_run  <= 1'b0;
          r_corr <= 1'b1;
        end
      end else if (r_corr) begin
        r_corr <= 1'b0;
        r_p    <= (r_acc >= NW) ? w_sub[K-1:0] : r_acc[K-1:0];
        r_done <= 1'b1;
      end
    end
  end

  assign p    = r_p;
  assign done = r_done;
endmodule

// File: rtl/rsa_encoder.sv
// RSA encrypt c = m^E mod N by left-to-right square-and-multiply in the Montgomery domain.
// Every MM op costs one issue cycle plus the K+2 cycles of mont_mul.
module rsa_encoder #(
  parameter int K      = rsa_pkg::K,
  parameter int N      = rsa_pkg::N,
  parameter int E      = rsa_pkg::E,
  parameter int E_W    = rsa_pkg::E_W,
  parameter int R1_MOD = rsa_pkg::R1_MOD,
  parameter int R2_MOD = rsa_pkg::R2_MOD
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [K-1:0] data_in,
  output logic [K-1:0] data_out,
  output logic         done,
  output logic         busy,
  output logic         err
);
  import rsa_pkg::*;

  localparam int BW = (E_W > 1) ? $clog2(E_W) : 1;
  localparam logic [K-1:0]   NK  = N[K-1:0];
  localparam logic [K-1:0]   R1K = R1_MOD[K-1:0];
  localparam logic [K-1:0]   R2K = R2_MOD[K-1:0];
  localparam logic [K-1:0]   ONE = {{(K-1){1'b0}}, 1'b1};
  localparam logic [E_W-1:0] EV  = E[E_W-1:0];

  rsa_state_t    r_state, w_next;
  logic [K-1:0]  r_m, r_xm, r_acc, r_dout;
  logic [BW-1:0] r_bit;
  logic          r_issued, r_err;
  logic          w_op, w_last, w_mm_start, w_mm_done;
  logic [K-1:0]  w_mm_a, w_mm_b, w_mm_p;

  assign w_op   = (r_state == S_TOMONT) || (r_state == S_SQR) ||
                  (r_state == S_MUL)    || (r_state == S_FROMMONT);
  assign w_last = (r_bit == '0);

  always_comb begin
    w_next     = r_state;
    w_mm_a     = r_acc;
    w_mm_b     = r_acc;
    w_mm_start = w_op && !r_issued;
    case (r_state)
      S_IDLE:  if (start) w_next = S_CHECK;
      S_CHECK: w_next = (r_m >= NK) ? S_DONE : S_TOMONT;
      S_TOMONT: begin
        w_mm_a = r_m;
        w_mm_b = R2K;
        if (w_mm_done) w_next = S_SQR;
      end
      S_SQR: if (w_mm_done) begin
        if (EV[r_bit])   w_next = S_MUL;
        else if (w_last) w_next = S_FROMMONT;
        else             w_next = S_SQR;
      end
      S_MUL: begin
        w_mm_b = r_xm;
        if (w_mm_done) w_next = w_last ? S_FROMMONT : S_SQR;
      end
      S_FROMMONT: begin
        w_mm_b = ONE;
        if (w_mm_done) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m <= '0; r_xm <= '0; r_acc <= '0; r_dout <= '0;
      r_bit <= '0; r_issued <= 1'b0; r_err <= 1'b0;
    end else begin
      if (w_mm_start)     r_issued <= 1'b1;
      else if (w_mm_done) r_issued <= 1'b0;
      case (r_state)
        S_IDLE: if (start) begin
          r_m    <= data_in;
          r_dout <= '0;
          r_err  <= 1'b0;
        end
        S_CHECK: begin
          r_err <= (r_m >= NK);
          r_acc <= R1K;
          r_bit <= BW'(E_W-1);
        end
        S_TOMONT: if (w_mm_done) r_xm <= w_mm_p;
        // a set exponent bit keeps the counter for the following multiply
        S_SQR: if (w_mm_done) begin
          r_acc <= w_mm_p;
          if (!EV[r_bit] && !w_last) r_bit <= r_bit - 1'b1;
        end
        S_MUL: if (w_mm_done) begin
          r_acc <= w_mm_p;
          if (!w_last) r_bit <= r_bit - 1'b1;
        end
        S_FROMMONT: if (w_mm_done) r_dout <= w_mm_p;
        default: ;
      endcase
    end
  end

  mont_mul #(.K(K), .N(N)) u_mm (
    .clk(clk), .rst(rst), .start(w_mm_start),
    .a(w_mm_a), .b(w_mm_b), .p(w_mm_p), .done(w_mm_done)
  );

  assign data_out = r_dout;
  assign done     = (r_state == S_DONE);
  assign busy     = (r_state != S_IDLE);
  assign err      = (r_state == S_DONE) && r_err;
endmodule

// File: tb/tb_rsa_encoder.sv
// Directed and round-trip bench for rsa_encoder (N=3551, E=5, decrypt exponent 1373).
module tb_rsa_encoder;
  logic        clk = 1'b0;
  logic        rst, start;
  logic [11:0] data_in, data_out;
  logic        done, busy, err;
  int n_pass = 0, n_tot = 0;

  always #5 clk = ~clk;

  rsa_encoder dut (
    .clk(clk), .rst(rst), .start(start), .data_in(data_in),
    .data_out(data_out), .done(done), .busy(busy), .err(err)
  );

  function automatic int modexp(input int b, input int e, input int n);
    longint r = 1, x = b % n;
    int ee = e;
    while (ee > 0) begin
      if (ee & 1) r = (r * x) % n;
      x = (x * x) % n;
      ee = ee >> 1;
    end
    return int'(r);
  endfunction

  // Accept edge is edge 0; latency is the edge at which done is first sampled high.
  task automatic do_run(input logic [11:0] m, output logic [11:0] c, output logic e, output int lat);
    int k = -1;
    bit got = 0;
    c = '0; e = 1'b0;
    @(negedge clk); start = 1'b1; data_in = m;
    while (!got && k < 400) begin
      @(posedge clk); k++;
      @(negedge clk); start = 1'b0;
      if (done) begin got = 1; c = data_out; e = err; end
    end
    lat = got ? k + 1 : -1;
  endtask

  task automatic test_reset();
    logic [11:0] c; logic e; int lat;
    rst = 1'b1; start = 1'b0; data_in = '0;
    #12;
    n_tot++; if ({done, busy, err, data_out} !== 15'd0) $display("FAIL reset_state: got %h want 0", {done, busy, err, data_out}); else n_pass++;
    @(negedge clk); rst = 1'b0;
    @(negedge clk); start = 1'b1; data_in = 12'd10;
    @(posedge clk); @(negedge clk); start = 1'b0;
    n_tot++; if (busy !== 1'b1) $display("FAIL busy_after_accept: got %b want 1", busy); else n_pass++;
    repeat (39) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    n_tot++; if ({done, busy, err, data_out} !== 15'd0) $display("FAIL reset_midrun: got %h want 0", {done, busy, err, data_out}); else n_pass++;
    @(negedge clk); rst = 1'b0;
    repeat (120) @(negedge clk);
    n_tot++; if ({done, busy} !== 2'b00) $display("FAIL reset_abort_idle: got %b want 00", {done, busy}); else n_pass++;
    do_run(12'd10, c, e, lat);
    n_tot++; if (c !== 12'd572) $display("FAIL reset_restart_data: got %0d want 572", c); else n_pass++;
    n_tot++; if (lat !== 107) $display("FAIL reset_restart_lat: got %0d want 107", lat); else n_pass++;
  endtask

  task automatic test_vectors();
    logic [11:0] vin [5] = '{12'd0, 12'd1, 12'd2, 12'd10, 12'd3550};
    logic [11:0] vexp[5] = '{12'd0, 12'd1, 12'd32, 12'd572, 12'd3550};
    logic [11:0] c; logic e; int lat;
    for (int i = 0; i < 5; i++) begin
      do_run(vin[i], c, e, lat);
      n_tot++; if (c !== vexp[i]) $display("FAIL vec_data m=%0d: got %0d want %0d", vin[i], c, vexp[i]); else n_pass++;
      n_tot++; if (lat !== 107) $display("FAIL vec_lat m=%0d: got %0d want 107", vin[i], lat); else n_pass++;
      n_tot++; if (e !== 1'b0) $display("FAIL vec_err m=%0d: got %b want 0", vin[i], e); else n_pass++;
    end
  endtask

  task automatic test_range();
    logic [11:0] vin[2] = '{12'd3551, 12'd4095};
    logic [11:0] c; logic e; int lat;
    for (int i = 0; i < 2; i++) begin
      do_run(vin[i], c, e, lat);
      n_tot++; if (e !== 1'b1) $display("FAIL range_err m=%0d: got %b want 1", vin[i], e); else n_pass++;
      n_tot++; if (c !== 12'd0) $display("FAIL range_data m=%0d: got %0d want 0", vin[i], c); else n_pass++;
      n_tot++; if (lat !== 2) $display("FAIL range_lat m=%0d: got %0d want 2", vin[i], lat); else n_pass++;
    end
    do_run(12'd2, c, e, lat);
    n_tot++; if (c !== 12'd32 || e !== 1'b0) $display("FAIL range_recover: got %0d/%b want 32/0", c, e); else n_pass++;
  endtask

  task automatic test_start_ignored();
    logic [11:0] c; logic e; int lat;
    int nd = 0, dk = -1;
    @(negedge clk); start = 1'b1; data_in = 12'd2;
    for (int k = 0; k <= 120; k++) begin
      @(posedge clk); @(negedge clk);
      // pulses land at edge 5 (mid-run) and edge 107 (the DONE cycle)
      start   = (k == 4 || k == 106);
      data_in = start ? 12'd7 : 12'd2;
      if (done) begin nd++; dk = k; c = data_out; end
    end
    start = 1'b0;
    n_tot++; if (nd !== 1) $display("FAIL ign_done_count: got %0d want 1", nd); else n_pass++;
    n_tot++; if (dk !== 106) $display("FAIL ign_done_edge: got %0d want 106", dk); else n_pass++;
    n_tot++; if (c !== 12'd32) $display("FAIL ign_data: got %0d want 32", c); else n_pass++;
    n_tot++; if (busy !== 1'b0) $display("FAIL ign_idle: got %b want 0", busy); else n_pass++;
    do_run(12'd2, c, e, lat);
    do_run(12'd10, c, e, lat);
    n_tot++; if (lat !== 107 || c !== 12'd572) $display("FAIL accept_after_done: got lat %0d data %0d want 107/572", lat, c); else n_pass++;
  endtask

  task automatic test_back_to_back();
    int nd = 0, prev = -1, low = 0;
    bit pdone = 0, pbusy = 1;
    @(negedge clk); start = 1'b1; data_in = 12'd10;
    for (int k = 0; k <= 330; k++) begin
      @(posedge clk); @(negedge clk);
      if (done) begin
        nd++;
        n_tot++; if (pdone) $display("FAIL b2b_done_width at k=%0d: got 2+ cycles want 1", k); else n_pass++;
        n_tot++; if (data_out !== 12'd572) $display("FAIL b2b_data at k=%0d: got %0d want 572", k, data_out); else n_pass++;
        n_tot++; if (k - prev !== ((prev < 0) ? 107 : 108)) $display("FAIL b2b_spacing at k=%0d: got %0d want %0d", k, k - prev, (prev < 0) ? 107 : 108); else n_pass++;
        prev = k;
      end
      if (!busy) begin
        low++;
        n_tot++; if (!pbusy) $display("FAIL b2b_busy_gap at k=%0d: got 2+ low cycles want 1", k); else n_pass++;
      end
      pdone = done; pbusy = busy;
    end
    start = 1'b0;
    n_tot++; if (nd !== 3) $display("FAIL b2b_done_count: got %0d want 3", nd); else n_pass++;
    n_tot++; if (low !== 3) $display("FAIL b2b_busy_low: got %0d want 3", low); else n_pass++;
    for (int k = 0; k < 200 && busy; k++) @(negedge clk);
  endtask

  task automatic test_round_trip();
    logic [11:0] c; logic e; int lat, m, ref_c, dec;
    for (int i = 0; i < 200; i++) begin
      m = int'($urandom_range(0, 3550));
      ref_c = modexp(m, 5, 3551);
      do_run(12'(m), c, e, lat);
      dec = modexp(int'(c), 1373, 3551);
      n_tot++; if (int'(c) !== ref_c) $display("FAIL rt_enc m=%0d: got %0d want %0d", m, c, ref_c); else n_pass++;
      n_tot++; if (dec !== m) $display("FAIL rt_dec m=%0d: got %0d want %0d", m, dec, m); else n_pass++;
    end
  endtask

  initial begin
    test_reset();
    test_vectors();
    test_range();
    test_start_ignored();
    test_back_to_back();
    test_round_trip();
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end
endmodule
